// File: rtl/fixed_point_adder_if.sv
// Operand/result bundle for the registered fixed-point adder.
// The master drives operands; the slave (the adder) returns the registered sum.
interface fixed_point_adder_if #(
   parameter int NUMBER_WIDTH = 3
);
   logic                    in_valid;
   logic [NUMBER_WIDTH-1:0] a;
   logic [NUMBER_WIDTH-1:0] b;
   logic                    out_valid;
   logic [NUMBER_WIDTH-1:0] result;
   logic                    overflow;

   modport master (
      output in_valid, a, b,
      input  out_valid, result, overflow
   );

   modport slave (
      input  in_valid, a, b,
      output out_valid, result, overflow
   );
endinterface

// File: rtl/fixed_point_adder.sv
// Registered two's-complement Q(I.F) adder, one-cycle latency, selectable wrap or saturate.
// Every output comes straight from a register; no input-to-output combinational path.
module fixed_point_adder #(
   parameter int INTEGER_PART_WIDTH    = 2,
   parameter int FRACTIONAL_PART_WIDTH = 1,
   parameter int SATURATE              = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   fixed_point_adder_if.slave bus
);
   localparam int NUMBER_WIDTH = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH;

   localparam logic [NUMBER_WIDTH-1:0] MAX_VALUE = {1'b0, {(NUMBER_WIDTH-1){1'b1}}};
   localparam logic [NUMBER_WIDTH-1:0] MIN_VALUE = {1'b1, {(NUMBER_WIDTH-1){1'b0}}};

   logic [NUMBER_WIDTH:0]   sum_full;
   logic                    overflow_next;
   logic [NUMBER_WIDTH-1:0] result_next;

   logic                    out_valid_reg;
   logic [NUMBER_WIDTH-1:0] result_reg;
   logic                    overflow_reg;

   // One guard bit is enough: the sum of two N-bit values fits in N+1 bits.
   assign sum_full      = {bus.a[NUMBER_WIDTH-1], bus.a} + {bus.b[NUMBER_WIDTH-1], bus.b};
   assign overflow_next = sum_full[NUMBER_WIDTH] ^ sum_full[NUMBER_WIDTH-1];

   always_comb begin
      result_next = sum_full[NUMBER_WIDTH-1:0];
      // The guard bit carries the true sign, so it picks the clamp direction.
      if ((SATURATE != 0) && overflow_next) begin
         result_next = sum_full[NUMBER_WIDTH] ? MIN_VALUE : MAX_VALUE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_reg <= 1'b0;
         result_reg    <= '0;
         overflow_reg  <= 1'b0;
      end else begin
         out_valid_reg <= bus.in_valid;
         if (bus.in_valid) begin
            result_reg   <= result_next;
            overflow_reg <= overflow_next;
         end
      end
   end

   assign bus.out_valid = out_valid_reg;
   assign bus.result    = result_reg;
   assign bus.overflow  = overflow_reg;
endmodule

// File: tb/tb_fixed_point_adder.sv
// Directed and exhaustive bench for fixed_point_adder at Q2.1, wrap and saturate instances side by side.
// Both instances see identical stimulus; expected values come from a table and an integer model.
module tb_fixed_point_adder;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [2:0] a;
   logic [2:0] b;

   int checks = 0;
   int errors = 0;

   fixed_point_adder_if #(.NUMBER_WIDTH(3)) if_w ();
   fixed_point_adder_if #(.NUMBER_WIDTH(3)) if_s ();

   assign if_w.in_valid = in_valid;
   assign if_w.a        = a;
   assign if_w.b        = b;
   assign if_s.in_valid = in_valid;
   assign if_s.a        = a;
   assign if_s.b        = b;

   fixed_point_adder #(.INTEGER_PART_WIDTH(2), .FRACTIONAL_PART_WIDTH(1), .SATURATE(0)) dut_w (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if_w.slave)
   );

   fixed_point_adder #(.INTEGER_PART_WIDTH(2), .FRACTIONAL_PART_WIDTH(1), .SATURATE(1)) dut_s (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if_s.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] a;
      logic [2:0] b;
      logic [2:0] res_w;
      logic       ovf_w;
      logic [2:0] res_s;
      logic       ovf_s;
   } vec_t;

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic vld,
                            input logic [2:0] rw, input logic ow,
                            input logic [2:0] rs, input logic os);
      check({tag, " wrap out_valid"}, {3'b0, if_w.out_valid}, {3'b0, vld});
      check({tag, " wrap result"},    {1'b0, if_w.result},    {1'b0, rw});
      check({tag, " wrap overflow"},  {3'b0, if_w.overflow},  {3'b0, ow});
      check({tag, " sat out_valid"},  {3'b0, if_s.out_valid}, {3'b0, vld});
      check({tag, " sat result"},     {1'b0, if_s.result},    {1'b0, rs});
      check({tag, " sat overflow"},   {3'b0, if_s.overflow},  {3'b0, os});
   endtask

   // Integer-domain reference: true sum, then range test, then wrap or clamp.
   function automatic void model(input logic [2:0] x, input logic [2:0] y, input bit sat,
                                 output logic [2:0] r, output logic o);
      int sx;
      int sy;
      int s;
      sx = int'($signed(x));
      sy = int'($signed(y));
      s  = sx + sy;
      o  = (s > 3) || (s < -4);
      if (sat && s > 3)       r = 3'b011;
      else if (sat && s < -4) r = 3'b100;
      else                    r = s[2:0];
   endfunction

   task automatic next_edge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t       vecs[7];
      logic [2:0] rw, rs;
      logic       ow, os;

      vecs[0] = '{3'b001, 3'b010, 3'b011, 1'b0, 3'b011, 1'b0};
      vecs[1] = '{3'b110, 3'b011, 3'b001, 1'b0, 3'b001, 1'b0};
      vecs[2] = '{3'b011, 3'b001, 3'b100, 1'b1, 3'b011, 1'b1};
      vecs[3] = '{3'b100, 3'b111, 3'b011, 1'b1, 3'b100, 1'b1};
      vecs[4] = '{3'b100, 3'b100, 3'b000, 1'b1, 3'b100, 1'b1};
      vecs[5] = '{3'b111, 3'b111, 3'b110, 1'b0, 3'b110, 1'b0};
      vecs[6] = '{3'b011, 3'b011, 3'b110, 1'b1, 3'b011, 1'b1};

      rst_n    = 1'b0;
      in_valid = 1'b0;
      a        = 3'b000;
      b        = 3'b000;
      repeat (2) next_edge();
      check_all("reset", 1'b0, 3'b000, 1'b0, 3'b000, 1'b0);
      rst_n = 1'b1;

      // Table vectors: each applied for one edge, checked 1 time unit later.
      for (int i = 0; i < 7; i++) begin
         in_valid = 1'b1;
         a        = vecs[i].a;
         b        = vecs[i].b;
         next_edge();
         $display("vec %0d a=%b b=%b wrap=%b/%b sat=%b/%b", i, a, b,
                  if_w.result, if_w.overflow, if_s.result, if_s.overflow);
         check_all($sformatf("vec%0d", i), 1'b1, vecs[i].res_w, vecs[i].ovf_w,
                   vecs[i].res_s, vecs[i].ovf_s);
      end

      // Idle cycles: out_valid drops, data holds the last accepted sum.
      in_valid = 1'b0;
      a        = 3'b001;
      b        = 3'b001;
      repeat (2) begin
         next_edge();
         $display("idle out_valid=%b result=%b/%b", if_w.out_valid, if_w.result, if_s.result);
         check_all("idle hold", 1'b0, 3'b110, 1'b1, 3'b011, 1'b1);
      end

      // Asynchronous reset between edges clears outputs without a clock.
      in_valid = 1'b1;
      a        = 3'b001;
      b        = 3'b010;
      next_edge();
      check_all("pre-reset", 1'b1, 3'b011, 1'b0, 3'b011, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      $display("async reset out_valid=%b result=%b", if_w.out_valid, if_w.result);
      check_all("async reset", 1'b0, 3'b000, 1'b0, 3'b000, 1'b0);
      #2 rst_n = 1'b1;

      // Exhaustive back-to-back sweep with a reset pulse in the middle.
      for (int i = 0; i < 64; i++) begin
         in_valid = 1'b1;
         a        = i[5:3];
         b        = i[2:0];
         next_edge();
         model(a, b, 1'b0, rw, ow);
         model(a, b, 1'b1, rs, os);
         $display("sweep a=%b b=%b wrap=%b/%b sat=%b/%b", a, b,
                  if_w.result, if_w.overflow, if_s.result, if_s.overflow);
         check_all($sformatf("sweep%0d", i), 1'b1, rw, ow, rs, os);
         if (i == 30) begin
            a = 3'b011;
            b = 3'b011;
            #1 rst_n = 1'b0;
            #1;
            check_all("sweep reset", 1'b0, 3'b000, 1'b0, 3'b000, 1'b0);
            #1 rst_n = 1'b1;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fixed_point_adder.md
# fixed_point_adder

Registered two's-complement fixed-point adder for the plotter's arithmetic datapath. It adds two signed Q(INTEGER_PART_WIDTH.FRACTIONAL_PART_WIDTH) operands and returns a result of the same format. Overflow handling is selectable: modular wrap-around or saturation. A sticky-free per-sample overflow flag is always reported, and a valid strobe travels with the data.

## Interface
- INTEGER_PART_WIDTH, default 2: integer bits, including the sign bit.
- FRACTIONAL_PART_WIDTH, default 1: fractional bits.
- SATURATE, default 0:
  - 0 = wrap, keeping the low NUMBER_WIDTH bits of the sum.
  - 1 = clamp to the most positive or most negative representable value.
- Derived constant NUMBER_WIDTH = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH. Not overridable.
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  a and b are valid this cycle.
- a  input  NUMBER_WIDTH  signed operand, value = a / 2^FRACTIONAL_PART_WIDTH.
- b  input  NUMBER_WIDTH  signed operand, same format.
- out_valid  output  1  result and overflow are valid.
- result  output  NUMBER_WIDTH  signed sum, same format.
- overflow  output  1  true sum was not representable; result is wrapped or clamped.

## Operation
- Binary points of a and b are aligned by construction, so no shifting is needed.
- Compute the full sum s = sign_extend(a) + sign_extend(b) in NUMBER_WIDTH+1 bits.
- Overflow = (a[MSB] == b[MSB]) && (s[NUMBER_WIDTH-1] != a[MSB]). Equivalently, s[NUMBER_WIDTH] != s[NUMBER_WIDTH-1].
- SATURATE=0: result = s[NUMBER_WIDTH-1:0], i.e. the sum modulo 2^NUMBER_WIDTH.
- SATURATE=1, no overflow: result = s[NUMBER_WIDTH-1:0].
- SATURATE=1, positive overflow (both operands non-negative): result = 0 followed by all 1s (MAX).
- SATURATE=1, negative overflow: result = 1 followed by all 0s (MIN).
- Overflow can never occur when operand signs differ.
- MIN + MIN:
  - wrap → 0, overflow=1.
  - saturate → MIN, overflow=1.
- No rounding: the fractional result is exact, because addition never loses fractional bits.
- in_valid=0: data registers hold their previous values; out_valid deasserts the next cycle.
- Any NUMBER_WIDTH ≥ 2 must be supported. FRACTIONAL_PART_WIDTH = 0 is legal (pure integer).

## Timing
- Latency is 1 cycle. Operands sampled at rising edge N appear on result, overflow and out_valid after edge N and hold until the next accepted sample.
- Full throughput: one new operand pair per cycle, with no backpressure and no ready signal.
- out_valid at edge N+1 equals in_valid sampled at edge N.
- Reset (rst_n=0, asynchronous) clears out_valid, result and overflow to 0 immediately, regardless of clk.
- Release of rst_n is synchronous to clk. The first sample is accepted on the first rising edge with rst_n=1.
- Reset asserted mid-stream discards the in-flight sample. No partial result is ever presented.
- All outputs come straight from registers. There is no combinational path from inputs to outputs.

## Test plan
All vectors use defaults: 3-bit Q2.1, range −2.0 … +1.5 in steps of 0.5.
- Reset: drive rst_n=0 with no clock edge → out_valid=0, result=3'b000, overflow=0 immediately.
- In range: a=3'b001 (0.5), b=3'b010 (1.0), in_valid=1 → next cycle result=3'b011 (1.5), overflow=0, out_valid=1.
- Mixed signs: a=3'b110 (−1.0), b=3'b011 (1.5) → result=3'b001 (0.5), overflow=0.
- Positive overflow: a=3'b011, b=3'b001.
  - SATURATE=0 → 3'b100, overflow=1.
  - SATURATE=1 → 3'b011, overflow=1.
- Negative overflow: a=3'b100, b=3'b111.
  - SATURATE=0 → 3'b011, overflow=1.
  - SATURATE=1 → 3'b100, overflow=1.
- Exhaustive back-to-back sweep: all 64 (a, b) pairs, one per cycle, for both SATURATE values.
  - Each result must match the golden model one cycle later.
  - out_valid must stay 1 throughout.
  - Pull rst_n low mid-sweep → outputs clear at once, and the sweep resumes cleanly after release.
